// File: rtl/tms_sdm_accum_pkg.sv
// Shared definitions for the SDM window accumulator: stream count, FSM encoding,
// and a constant clog2 used to validate the stream-index width.
package tms_sdm_accum_pkg;

  localparam int NCH_DEF = 19;
  localparam int DCW     = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Each SDM delivers an OUT1 and an OUT2 bit per sample.
  function automatic int nstream(input int nch);
    return 2 * nch;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/tms_sdm_ch_accum.sv
// One stream's ones counter plus its shadow copy of the last completed window sum.
module tms_sdm_ch_accum #(
  parameter int ACCW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            bit_i,
  input  logic            valid_i,
  input  logic            clr_i,
  input  logic            end_i,
  input  logic            load_en_i,
  output logic [ACCW-1:0] sum_o
);

  logic [ACCW-1:0] acc_q, acc_d;
  logic [ACCW-1:0] shadow_q, shadow_d;
  logic [ACCW-1:0] acc_inc;

  // The window-end sample itself belongs to the completed sum.
  assign acc_inc = acc_q + ACCW'(bit_i);

  always_comb begin
    acc_d    = acc_q;
    shadow_d = shadow_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (valid_i) begin
      acc_d = end_i ? '0 : acc_inc;
    end
    if (valid_i && end_i && load_en_i) begin
      shadow_d = acc_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      shadow_q <= '0;
    end else begin
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
    end
  end

  assign sum_o = shadow_q;

endmodule

// File: rtl/tms_sdm_accum.sv
// Counts ones per SDM stream over a WIN_LEN-sample window and streams the completed
// sums one stream per beat; a window ending while a frame is still being sent is dropped.
module tms_sdm_accum
  import tms_sdm_accum_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int ACCW = 16,
  parameter int CHW  = 6,
  parameter int FIDW = 16
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              ENABLE,
  input  logic [ACCW-1:0]   WIN_LEN,
  input  logic [NCH*2-1:0]  DIN,
  input  logic              DIN_VALID,
  output logic [ACCW-1:0]   SUM,
  output logic [CHW-1:0]    SUM_CH,
  output logic [FIDW-1:0]   SUM_FID,
  output logic              SUM_LAST,
  output logic              SUM_VALID,
  input  logic              SUM_READY,
  output logic              OVERFLOW,
  input  logic              CLEAR_OVF,
  output logic [DCW-1:0]    DROP_CNT
);

  localparam int             NSTREAM = nstream(NCH);
  localparam logic [CHW-1:0] LAST_CH = CHW'(NSTREAM - 1);

  if (clog2(NSTREAM) > CHW) begin : g_chw_check
    $error("tms_sdm_accum: CHW too narrow for the stream count");
  end

  logic                    run, smp, win_end, hs, load, drop;
  logic [ACCW-1:0]         win_q, win_d, win_eff;
  logic [ACCW-1:0]         scnt_q, scnt_d;
  logic                    active_q, active_d;
  logic [FIDW-1:0]         fid_q, fid_d;
  logic                    ovf_q, ovf_d;
  logic [DCW-1:0]          dcnt_q, dcnt_d;
  state_e                  state_q;
  logic [CHW-1:0]          ch_q;
  logic [FIDW-1:0]         tag_q;
  logic                    valid_q, last_q;
  logic [NSTREAM*ACCW-1:0] shadow;
  logic [ACCW-1:0]         sum_mux;

  // A zero window length is treated exactly like ENABLE low.
  assign run     = ENABLE & (WIN_LEN != '0);
  assign smp     = run & DIN_VALID;
  assign win_eff = active_q ? win_q : WIN_LEN;
  assign win_end = smp & (scnt_q == win_eff - 1'b1);

  assign hs   = valid_q & SUM_READY;
  assign load = win_end & ((state_q == ST_IDLE) | (hs & (ch_q == LAST_CH)));
  assign drop = win_end & ~load;

  always_comb begin
    win_d    = win_q;
    scnt_d   = scnt_q;
    active_d = active_q;
    fid_d    = fid_q;
    if (!run) begin
      scnt_d   = '0;
      active_d = 1'b0;
    end else if (smp) begin
      if (!active_q) begin
        win_d = WIN_LEN;
      end
      if (win_end) begin
        scnt_d   = '0;
        active_d = 1'b0;
        fid_d    = fid_q + 1'b1;
      end else begin
        scnt_d   = scnt_q + 1'b1;
        active_d = 1'b1;
      end
    end
  end

  // A drop coincident with CLEAR_OVF restarts the count at one rather than zero.
  always_comb begin
    ovf_d  = ovf_q;
    dcnt_d = dcnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (CLEAR_OVF) begin
        dcnt_d = DCW'(1);
      end else if (dcnt_q != '1) begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end else if (CLEAR_OVF) begin
      ovf_d  = 1'b0;
      dcnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      win_q    <= '0;
      scnt_q   <= '0;
      active_q <= 1'b0;
      fid_q    <= '0;
      ovf_q    <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      win_q    <= win_d;
      scnt_q   <= scnt_d;
      active_q <= active_d;
      fid_q    <= fid_d;
      ovf_q    <= ovf_d;
      dcnt_q   <= dcnt_d;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            state_q <= ST_SEND;
            ch_q    <= '0;
            tag_q   <= fid_q;
            valid_q <= 1'b1;
            last_q  <= (NSTREAM == 1);
          end
        end
        ST_SEND: begin
          if (load) begin
            ch_q    <= '0;
            tag_q   <= fid_q;
            last_q  <= (NSTREAM == 1);
          end else if (hs) begin
            if (ch_q == LAST_CH) begin
              state_q <= ST_IDLE;
              ch_q    <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              ch_q   <= ch_q + 1'b1;
              last_q <= ((ch_q + 1'b1) == LAST_CH);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NSTREAM; k++) begin : g_ch
    tms_sdm_ch_accum #(
      .ACCW(ACCW)
    ) u_ch (
      .clk_i    (CLK),
      .rst_ni   (RESETN),
      .bit_i    (DIN[k]),
      .valid_i  (smp),
      .clr_i    (~run),
      .end_i    (win_end),
      .load_en_i(load),
      .sum_o    (shadow[k*ACCW +: ACCW])
    );
  end

  always_comb begin
    sum_mux = '0;
    for (int k = 0; k < NSTREAM; k++) begin
      if (ch_q == CHW'(k)) begin
        sum_mux = shadow[k*ACCW +: ACCW];
      end
    end
  end

  assign SUM       = valid_q ? sum_mux : '0;
  assign SUM_CH    = ch_q;
  assign SUM_FID   = tag_q;
  assign SUM_LAST  = last_q;
  assign SUM_VALID = valid_q;
  assign OVERFLOW  = ovf_q;
  assign DROP_CNT  = dcnt_q;

endmodule

// File: tb/tb_tms_sdm_accum.sv
// Directed bench for tms_sdm_accum: a table of single-window frames plus
// hand-written sequences for window changes, drops, back-to-back frames and reset.
module tb_tms_sdm_accum;

  localparam int NS = 38;

  logic        CLK, RESETN, ENABLE, DIN_VALID, SUM_READY, CLEAR_OVF;
  logic [15:0] WIN_LEN;
  logic [37:0] DIN;
  logic [15:0] SUM, SUM_FID, DROP_CNT;
  logic [5:0]  SUM_CH;
  logic        SUM_LAST, SUM_VALID, OVERFLOW;

  int n_vec = 0;
  int n_err = 0;

  tms_sdm_accum dut (
    .CLK(CLK), .RESETN(RESETN), .ENABLE(ENABLE), .WIN_LEN(WIN_LEN),
    .DIN(DIN), .DIN_VALID(DIN_VALID), .SUM(SUM), .SUM_CH(SUM_CH),
    .SUM_FID(SUM_FID), .SUM_LAST(SUM_LAST), .SUM_VALID(SUM_VALID),
    .SUM_READY(SUM_READY), .OVERFLOW(OVERFLOW), .CLEAR_OVF(CLEAR_OVF),
    .DROP_CNT(DROP_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          win;
    logic [37:0] a;
    logic [37:0] b;
    bit          tog;
    logic [15:0] fid;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Samples alternate a, b, a, ... starting with a at the first window sample.
  function automatic int msum(input int win, input logic [37:0] a, input logic [37:0] b, input int k);
    return (a[k] ? (win + 1) / 2 : 0) + (b[k] ? win / 2 : 0);
  endfunction

  task automatic feed(input int n, input logic [37:0] a, input logic [37:0] b, input bit clr_last);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      DIN       = (i % 2 == 0) ? a : b;
      DIN_VALID = 1'b1;
      CLEAR_OVF = clr_last && (i == n - 1);
    end
    @(negedge CLK);
    DIN_VALID = 1'b0;
    CLEAR_OVF = 1'b0;
    DIN       = '0;
  endtask

  task automatic collect(input int win, input logic [37:0] a, input logic [37:0] b,
                         input logic [15:0] fid, input bit tog, input bit keep, output int gap);
    int idx, cyc;
    bit seen;
    idx = 0; cyc = 0; gap = 0; seen = 0;
    while (idx < NS && cyc < 2000) begin
      @(negedge CLK);
      SUM_READY = tog ? (cyc % 2 == 1) : 1'b1;
      if (SUM_VALID) begin
        seen = 1;
        chk($sformatf("ch[%0d]", idx), SUM_CH, idx);
        chk($sformatf("sum[%0d]", idx), SUM, msum(win, a, b, idx));
        chk($sformatf("fid[%0d]", idx), SUM_FID, fid);
        chk($sformatf("last[%0d]", idx), SUM_LAST, idx == NS - 1);
        if (SUM_READY) idx++;
      end else if (!seen) begin
        gap++;
      end else begin
        chk("valid_midframe", SUM_VALID, 1);
      end
      cyc++;
    end
    if (idx < NS) chk("collect_timeout", idx, NS);
    if (!keep) begin
      @(negedge CLK);
      SUM_READY = 1'b0;
    end
  endtask

  vec_t tbl[7];
  localparam logic [37:0] ONES = {38{1'b1}};

  initial begin
    int g, vcnt;
    tbl[0] = '{8,      38'h3,           38'h1,           1'b0, 16'd0};
    tbl[1] = '{8,      38'h3,           38'h1,           1'b0, 16'd1};
    tbl[2] = '{8,      38'h3,           38'h1,           1'b1, 16'd2};
    tbl[3] = '{1,      38'h2A_5A5A_0F0F, 38'h0,          1'b0, 16'd3};
    tbl[4] = '{1,      38'h15_A5A5_F0F0, ONES,           1'b0, 16'd4};
    tbl[5] = '{3,      38'h3F_0000_FFFF, 38'h00_FFFF_00FF, 1'b1, 16'd5};
    tbl[6] = '{65535,  ONES,            ONES,            1'b0, 16'd6};

    RESETN = 1'b0; ENABLE = 1'b0; WIN_LEN = 16'd8; DIN = '0; DIN_VALID = 1'b0;
    SUM_READY = 1'b0; CLEAR_OVF = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rst_valid", SUM_VALID, 0);
    RESETN = 1'b1;
    @(negedge CLK);
    chk("rst_sum", SUM, 0);
    chk("rst_ch", SUM_CH, 0);
    chk("rst_fid", SUM_FID, 0);
    chk("rst_last", SUM_LAST, 0);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_dcnt", DROP_CNT, 0);

    // Samples arrive with ENABLE low: nothing may be produced.
    vcnt = 0;
    DIN = ONES; DIN_VALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (SUM_VALID) vcnt++;
    end
    DIN_VALID = 1'b0; DIN = '0;
    chk("idle_no_valid", vcnt, 0);
    ENABLE = 1'b1;

    for (int v = 0; v < 7; v++) begin
      WIN_LEN   = tbl[v].win[15:0];
      SUM_READY = 1'b0;
      feed(tbl[v].win, tbl[v].a, tbl[v].b, 1'b0);
      chk($sformatf("lat_valid_v%0d", v), SUM_VALID, 1);
      collect(tbl[v].win, tbl[v].a, tbl[v].b, tbl[v].fid, tbl[v].tog, 1'b0, g);
    end

    // WIN_LEN changed mid-window only takes effect on the next window.
    WIN_LEN = 16'd8;
    feed(4, ONES, ONES, 1'b0);
    WIN_LEN = 16'd16;
    feed(4, ONES, ONES, 1'b0);
    chk("winchg_end8", SUM_VALID, 1);
    collect(8, ONES, ONES, 16'd7, 1'b0, 1'b0, g);
    feed(15, ONES, ONES, 1'b0);
    chk("winchg_not_early", SUM_VALID, 0);
    feed(1, ONES, ONES, 1'b0);
    chk("winchg_end16", SUM_VALID, 1);
    collect(16, ONES, ONES, 16'd8, 1'b0, 1'b0, g);

    // ENABLE dropped mid-window discards the partial sums.
    WIN_LEN = 16'd8;
    feed(5, ONES, ONES, 1'b0);
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    ENABLE = 1'b1;
    feed(8, 38'h1, 38'h0, 1'b0);
    chk("en_drop_valid", SUM_VALID, 1);
    collect(8, 38'h1, 38'h0, 16'd9, 1'b0, 1'b0, g);

    // Overflow: frame 10 held in SEND while frames 11..13 are dropped.
    WIN_LEN = 16'd4;
    SUM_READY = 1'b0;
    feed(4, ONES, ONES, 1'b0);
    feed(4, 38'h0, 38'h0, 1'b0);
    chk("ovf_set", OVERFLOW, 1);
    chk("ovf_dcnt1", DROP_CNT, 1);
    feed(4, 38'h0, 38'h0, 1'b0);
    chk("ovf_dcnt2", DROP_CNT, 2);
    feed(4, 38'h0, 38'h0, 1'b1);
    chk("ovf_clr_drop_ovf", OVERFLOW, 1);
    chk("ovf_clr_drop_dcnt", DROP_CNT, 1);
    collect(4, ONES, ONES, 16'd10, 1'b0, 1'b0, g);
    feed(4, 38'h5, 38'h6, 1'b0);
    collect(4, 38'h5, 38'h6, 16'd14, 1'b0, 1'b0, g);
    chk("ovf_sticky", OVERFLOW, 1);
    @(negedge CLK); CLEAR_OVF = 1'b1;
    @(negedge CLK); CLEAR_OVF = 1'b0;
    chk("clr_ovf", OVERFLOW, 0);
    chk("clr_dcnt", DROP_CNT, 0);

    // Window end lands on the LAST handshake: frames go back to back.
    WIN_LEN = 16'd38;
    fork
      feed(3 * NS, 38'h3, 38'h1, 1'b0);
      begin
        int g2, g3;
        collect(NS, 38'h3, 38'h1, 16'd15, 1'b0, 1'b1, g);
        collect(NS, 38'h3, 38'h1, 16'd16, 1'b0, 1'b1, g2);
        chk("b2b_gap2", g2, 0);
        collect(NS, 38'h3, 38'h1, 16'd17, 1'b0, 1'b0, g3);
        chk("b2b_gap3", g3, 0);
      end
    join
    chk("b2b_ovf", OVERFLOW, 0);
    chk("b2b_dcnt", DROP_CNT, 0);

    // Reset while a frame is being sent.
    WIN_LEN = 16'd2;
    SUM_READY = 1'b0;
    feed(2, ONES, ONES, 1'b0);
    chk("send_before_rst", SUM_VALID, 1);
    #2 RESETN = 1'b0;
    #1;
    chk("async_rst_valid", SUM_VALID, 0);
    chk("async_rst_sum", SUM, 0);
    @(negedge CLK);
    RESETN = 1'b1;
    WIN_LEN = 16'd1;
    feed(1, 38'h2, 38'h0, 1'b0);
    collect(1, 38'h2, 38'h0, 16'd0, 1'b0, 1'b0, g);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tms_sdm_accum.md
Name: tms_sdm_accum

Overview:
Downstream consumer of the SDM receiver's sampled bitstreams (DOUT/DOUT_VALID, 2 streams per SDM). It counts the ones in each stream over a programmable window of valid samples, which is a first-order decimation. Completed window sums are double-buffered and streamed out one stream at a time over a valid/ready interface to the readout FIFO/control interface.

Parameters:
NCH, 19, number of SDMs; NSTREAM = 2*NCH; stream k = 2*ch + (0: OUT1, 1: OUT2)
ACCW, 16, accumulator/sum width; the maximum window is 2^ACCW-1 samples
CHW, 6, stream index width; ceil(log2(NSTREAM)) must be <= CHW
FIDW, 16, frame ID width

Ports:
CLK  in  1  system clock; same domain as the receiver's DOUT
RESETN  in  1  asynchronous, active-low reset
ENABLE  in  1  accumulation enable, level
WIN_LEN  in  ACCW  samples per window; 0 = hold idle
DIN  in  NCH*2  sampled SDM bits from the receiver
DIN_VALID  in  1  one-cycle strobe per sample
SUM  out  ACCW  window sum for stream SUM_CH
SUM_CH  out  CHW  stream index 0..NSTREAM-1
SUM_FID  out  FIDW  frame ID of the current sum
SUM_LAST  out  1  high with the SUM_CH = NSTREAM-1 beat
SUM_VALID  out  1  output beat valid
SUM_READY  in  1  downstream accept
OVERFLOW  out  1  sticky: a frame was dropped
CLEAR_OVF  in  1  one-cycle pulse; clears OVERFLOW and DROP_CNT
DROP_CNT  out  16  dropped-frame count, saturating at 0xFFFF

Behaviour:
- Reset values: all outputs 0; accumulators, shadow registers, sample counter and frame ID cleared; FSM in IDLE.
- Window latch: WIN_LEN is captured into win_q at the start of every window. A window starts on the first valid sample after ENABLE rises, or right after the previous window ends. Changing WIN_LEN mid-window has no effect until the next window.
- Accumulate: on each cycle with ENABLE=1, win_q!=0 and DIN_VALID=1:
  - acc[k] += DIN[k] for every stream k.
  - scnt += 1.
- Window end: when the sample with scnt == win_q-1 arrives:
  - the completed sum (acc[k]+DIN[k]) goes to the shadow register or is dropped, per the FSM rules below;
  - acc is cleared, scnt is cleared, and FID increments (modulo 2^FIDW, including dropped frames).
- Sum range: sums are at most win_q <= 2^ACCW-1, so no arithmetic overflow is possible.
- ENABLE low: acc and scnt clear immediately; a frame already in shadow/SEND still drains. WIN_LEN=0 behaves the same as ENABLE low.
- Output FSM states: IDLE, SEND.
  - IDLE + window end -> load shadow and FID tag, ch=0, go SEND. SUM_VALID rises the cycle after the window-end sample (latency 1).
  - SEND: SUM_VALID=1; SUM=shadow[ch], SUM_CH=ch, SUM_FID=tag, SUM_LAST=(ch==NSTREAM-1). All outputs hold stable while SUM_READY=0.
  - SEND, handshake (VALID & READY) with ch<NSTREAM-1 -> ch+1.
  - SEND, handshake with ch==NSTREAM-1 -> IDLE.
- Simultaneous events:
  - Window end in the same cycle as the final (LAST) handshake -> new frame is loaded, FSM stays in SEND with ch=0; no drop.
  - Window end in SEND before the LAST handshake -> new frame dropped; shadow untouched; OVERFLOW set; DROP_CNT +1 (saturating).
  - CLEAR_OVF coincident with a drop -> the drop wins: OVERFLOW=1, DROP_CNT=1.
- Reset mid-operation: asynchronous clear of everything; any partial frame is discarded and SUM_VALID drops immediately.

Decomposition:
- Shared header tms_sdm_defs.vh:
  - NCH default and the NSTREAM derivation;
  - FSM state encodings (IDLE=0, SEND=1);
  - clog2 function used to check CHW.
- Natural sub-module: tms_sdm_ch_accum, one per stream (generate loop). It holds the ACCW accumulator plus the shadow register, with inputs bit, valid, clr, end, load_en.
- The top level holds the sample counter, window latch, FSM, output mux and overflow logic.

Test Plan:
- Reset/idle: hold RESETN=0 then release, ENABLE=0 -> all outputs 0, no SUM_VALID for 100 cycles.
- Basic window: WIN_LEN=8, SUM_READY=1, stream 0 all ones, stream 1 = 1010..., others 0 -> SUM_VALID one cycle after the 8th sample; 38 consecutive beats with stream 0 SUM=8, stream 1 SUM=4, others 0; SUM_LAST on SUM_CH=37; SUM_FID=0, then 1 for the next frame.
- Backpressure: SUM_READY toggling 1/0 -> each beat held stable until accepted; no beat skipped or duplicated; sums are identical to the unstalled run.
- Overflow: WIN_LEN=4, SUM_READY=0 across two window ends -> OVERFLOW=1, DROP_CNT=1; the first frame (FID 0) is still delivered intact; the next delivered frame has FID 2. Then pulse CLEAR_OVF -> OVERFLOW=0, DROP_CNT=0.
- Boundary: window end on the same cycle as the LAST handshake (WIN_LEN=38, DIN_VALID every cycle, READY=1) -> back-to-back frames with no drop. WIN_LEN=1 -> each sum equals that single DIN bit. WIN_LEN=0xFFFF with all ones -> SUM=0xFFFF with no wrap.
- Mid-operation: change WIN_LEN 8->16 mid-window -> the current window ends at 8 and the next at 16. Drop ENABLE mid-window -> partial sums discarded. Assert RESETN low during SEND -> SUM_VALID=0 asynchronously.
